// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : memory stage (execute -> bus load/store -> writeback), rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Evalid,
  output logic                  Mready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [STRB_WIDTH-1:0] mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  input  logic                  mem_rsp_err,
  output logic                  Mvalid,
  input  logic                  Wready,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic [DATA_WIDTH-1:0] ALUResultOut,
  output logic                  MemErr
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]            state;
  logic [1:0]            next_state;

  // Latched instruction attributes needed after acceptance for load alignment.
  logic                  lat_read;
  logic [2:0]            lat_f3;
  logic [1:0]            lat_addr_lo;

  logic                  is_mem;
  logic                  load_ok;
  logic                  store_ok;
  logic                  misaligned;
  logic                  fault;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [STRB_WIDTH-1:0] st_wstrb;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_data;

  // Instruction decode on the execute-side inputs, used only at acceptance.
  always_comb begin
    is_mem     = MemRead | MemWrite;
    store_ok   = 1'b0;
    load_ok    = 1'b0;
    misaligned = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b010: begin
        store_ok = 1'b1;
        load_ok  = 1'b1;
      end
      3'b100, 3'b101: load_ok = 1'b1;
      default: ;
    endcase
    case (Funct3[1:0])
      2'b01:   misaligned = ALUResult[0];
      2'b10:   misaligned = |ALUResult[1:0];
      default: misaligned = 1'b0;
    endcase
    fault = (MemRead & MemWrite) | (MemRead & ~load_ok) |
            (MemWrite & ~store_ok) | misaligned;
  end

  always_comb begin
    st_wdata = WriteData;
    st_wstrb = 4'b1111;
    case (Funct3[1:0])
      2'b00: begin
        st_wdata = {4{WriteData[7:0]}};
        st_wstrb = 4'b0001 << ALUResult[1:0];
      end
      2'b01: begin
        st_wdata = {2{WriteData[15:0]}};
        st_wstrb = 4'b0011 << {ALUResult[1], 1'b0};
      end
      default: begin
        st_wdata = WriteData;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Lane selection and extension of the raw response word.
  always_comb begin
    case (lat_addr_lo)
      2'd0:    byte_sel = mem_rsp_rdata[7:0];
      2'd1:    byte_sel = mem_rsp_rdata[15:8];
      2'd2:    byte_sel = mem_rsp_rdata[23:16];
      default: byte_sel = mem_rsp_rdata[31:24];
    endcase
    half_sel = lat_addr_lo[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (lat_f3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (Evalid) begin
          next_state = (!is_mem || fault) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          next_state = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (mem_rsp_valid) begin
          next_state = S_DONE;
        end
      end
      default: begin
        if (Wready) begin
          next_state = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    Mready        = (state == S_IDLE);
    Mvalid        = (state == S_DONE);
    mem_req_valid = (state == S_REQ);
  end

  // Result and request registers; request fields stay frozen from acceptance on.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_read      <= 1'b0;
      lat_f3        <= 3'd0;
      lat_addr_lo   <= 2'd0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      ReadData      <= '0;
      ALUResultOut  <= '0;
      MemErr        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Evalid) begin
            lat_read     <= MemRead;
            lat_f3       <= Funct3;
            lat_addr_lo  <= ALUResult[1:0];
            ALUResultOut <= ALUResult;
            ReadData     <= '0;
            MemErr       <= is_mem & fault;
            if (is_mem && !fault) begin
              mem_req_addr  <= {ALUResult[31:2], 2'b00};
              mem_req_wen   <= MemWrite;
              mem_req_wdata <= MemWrite ? st_wdata : '0;
              mem_req_wstrb <= MemWrite ? st_wstrb : '0;
            end
          end
        end
        S_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            MemErr   <= mem_rsp_err;
            ReadData <= (lat_read && !mem_rsp_err) ? load_data : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit : randomized bench with transaction-level reference model, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  logic        clk;
  logic        rstn;
  logic        Evalid;
  logic        Mready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic        Mvalid;
  logic        Wready;
  logic [31:0] ReadData;
  logic [31:0] ALUResultOut;
  logic        MemErr;

  mem_access_unit #(.DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .Evalid(Evalid), .Mready(Mready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err), .Mvalid(Mvalid), .Wready(Wready),
    .ReadData(ReadData), .ALUResultOut(ALUResultOut), .MemErr(MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference model state: what the current transaction must look like.
  logic        model_busy, model_reqphase, model_done;
  logic        m_has_req, m_wen, m_err;
  logic [31:0] m_addr, m_wdata, m_rd, m_alu;
  logic [3:0]  m_wstrb;

  int          hs_count, mv_count;
  logic [31:0] last_addr, last_wdata, last_rd, last_alu;
  logic [3:0]  last_wstrb;
  logic        last_wen, last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_fault(input logic r, input logic w, input logic [2:0] f3,
                                       input logic [31:0] a);
    logic legal;
    if (r) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else   legal = (f3 inside {3'd0, 3'd1, 3'd2});
    return (r && w) || !legal || ((a % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] res;
    int sz;
    sz  = acc_size(f3);
    res = 32'd0;
    for (int i = 0; i < 4; i++) res = res | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return res;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] v, mask;
    int sz;
    sz   = acc_size(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rdata >> (8 * (a % 4))) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic set_model(input logic r, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    m_alu     = a;
    m_rd      = 32'd0;
    m_has_req = (r || w) && !model_fault(r, w, f3, a);
    m_err     = (r || w) && !m_has_req;
    m_addr    = a & 32'hFFFF_FFFC;
    m_wen     = w;
    m_wdata   = w ? model_wdata(f3, wd) : 32'd0;
    m_wstrb   = w ? model_wstrb(f3, a) : 4'd0;
  endtask

  task automatic stray_rsp();
    mem_rsp_valid = ($urandom_range(0, 2) == 0);
    mem_rsp_rdata = $urandom;
    mem_rsp_err   = 1'($urandom);
  endtask

  task automatic scramble_inputs();
    MemRead   = 1'($urandom);
    MemWrite  = 1'($urandom);
    Funct3    = 3'($urandom);
    ALUResult = $urandom;
    WriteData = $urandom;
  endtask

  // One full instruction from acceptance to writeback transfer.
  task automatic run_txn(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdata, input logic err,
                         input int req_stall, input int rsp_dly, input int wb_stall);
    int n, hs0, mv0;
    n = 0;
    while (!Mready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!Mready) chk("mready_timeout", 32'(Mready), 32'd1);
    MemRead = r; MemWrite = w; Funct3 = f3; ALUResult = a; WriteData = wd;
    Wready = (wb_stall == 0);
    set_model(r, w, f3, a, wd);
    Evalid = 1'b1;
    hs0 = hs_count;
    mv0 = mv_count;
    @(posedge clk); #1;
    Evalid = 1'b0;
    scramble_inputs();
    model_busy = 1'b1;
    if (m_has_req) begin
      model_reqphase = 1'b1;
      repeat (req_stall) begin
        mem_req_ready = 1'b0;
        stray_rsp();
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      stray_rsp();
      @(posedge clk); #1;
      model_reqphase = 1'b0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      repeat (rsp_dly) begin
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = rdata;
      mem_rsp_err   = err;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      m_err = err;
      m_rd  = (r && !err) ? model_load(f3, a, rdata) : 32'd0;
    end
    model_done = 1'b1;
    repeat (wb_stall) begin
      Wready = 1'b0;
      stray_rsp();
      @(posedge clk); #1;
    end
    Wready = 1'b1;
    @(posedge clk); #1;
    model_done    = 1'b0;
    model_busy    = 1'b0;
    mem_rsp_valid = 1'b0;
    Wready        = 1'b0;
    chk("req_count", 32'(hs_count - hs0), m_has_req ? 32'd1 : 32'd0);
    chk("mvalid_cycles", 32'(mv_count - mv0), 32'(wb_stall + 1));
  endtask

  initial begin
    logic        r, w;
    logic [2:0]  f3;
    logic [31:0] a;
    int          op;
    n_checks = 0; n_pass = 0; hs_count = 0; mv_count = 0;
    model_busy = 0; model_reqphase = 0; model_done = 0;
    m_has_req = 0; m_wen = 0; m_err = 0; m_addr = 0; m_wdata = 0; m_rd = 0; m_alu = 0; m_wstrb = 0;
    last_addr = 0; last_wdata = 0; last_rd = 0; last_alu = 0; last_wstrb = 0; last_wen = 0; last_err = 0;
    rstn = 1'b0; Evalid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0; Wready = 1'b0;
    scramble_inputs();

    // Compare process: DUT outputs against the model on every clock while out of reset.
    fork
      forever begin
        @(negedge clk);
        if (rstn) begin
          chk("Mready", 32'(Mready), 32'(!model_busy));
          chk("Mvalid", 32'(Mvalid), 32'(model_done));
          chk("mem_req_valid", 32'(mem_req_valid), 32'(model_reqphase));
          if (mem_req_valid) begin
            chk("req_addr", mem_req_addr, m_addr);
            chk("req_wen", 32'(mem_req_wen), 32'(m_wen));
            chk("req_wdata", mem_req_wdata, m_wdata);
            chk("req_wstrb", 32'(mem_req_wstrb), 32'(m_wstrb));
            last_addr = mem_req_addr; last_wen = mem_req_wen;
            last_wdata = mem_req_wdata; last_wstrb = mem_req_wstrb;
            if (mem_req_ready) hs_count++;
          end
          if (Mvalid) begin
            chk("ReadData", ReadData, m_rd);
            chk("ALUResultOut", ALUResultOut, m_alu);
            chk("MemErr", 32'(MemErr), 32'(m_err));
            last_rd = ReadData; last_alu = ALUResultOut; last_err = MemErr;
            mv_count++;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_Mready", 32'(Mready), 32'd1);
    chk("rst_Mvalid", 32'(Mvalid), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_ReadData", ReadData, 32'd0);
    chk("rst_ALUResultOut", ALUResultOut, 32'd0);
    chk("rst_MemErr", 32'(MemErr), 32'd0);
    rstn = 1'b1;

    // Non-memory op with Wready already high.
    run_txn(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    chk("nonmem_alu", last_alu, 32'h1234_5678);
    chk("nonmem_rd", last_rd, 32'h0);
    // LB / LBU from byte 3 with a 2-cycle request stall.
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1'b0, 2, 0, 0);
    chk("lb_addr", last_addr, 32'h0000_1000);
    chk("lb_wen", 32'(last_wen), 32'd0);
    chk("lb_rd", last_rd, 32'hFFFF_FF80);
    chk("lb_err", 32'(last_err), 32'd0);
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1'b0, 2, 1, 0);
    chk("lbu_rd", last_rd, 32'h0000_0080);
    // SH to the upper halfword.
    run_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h5555_5555, 1'b0, 1, 0, 0);
    chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    chk("sh_wstrb", 32'(last_wstrb), 32'h0000_000C);
    chk("sh_wen", 32'(last_wen), 32'd1);
    chk("sh_rd", last_rd, 32'h0);
    // Misaligned LW, then bus error on an aligned LW.
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    chk("mis_err", 32'(last_err), 32'd1);
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h1111_2222, 1'b1, 0, 2, 1);
    chk("buserr_err", 32'(last_err), 32'd1);
    chk("buserr_rd", last_rd, 32'h0);
    // Writeback backpressure for 5 cycles.
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 5);
    chk("bp_rd", last_rd, 32'hCAFE_F00D);

    // Reset while waiting for a load response, then a stray response.
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0000_0040; WriteData = 32'h0;
    set_model(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    Evalid = 1'b1;
    @(posedge clk); #1;
    Evalid = 1'b0;
    model_busy = 1'b1; model_reqphase = 1'b1; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; model_reqphase = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    model_busy = 1'b0;
    chk("midrst_Mready", 32'(Mready), 32'd1);
    chk("midrst_Mvalid", 32'(Mvalid), 32'd0);
    chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_MemErr", 32'(MemErr), 32'd0);
    chk("midrst_ReadData", ReadData, 32'd0);
    chk("midrst_ALUResultOut", ALUResultOut, 32'd0);
    chk("midrst_req_addr", mem_req_addr, 32'd0);
    chk("midrst_req_wdata", mem_req_wdata, 32'd0);
    chk("midrst_req_wstrb", 32'(mem_req_wstrb), 32'd0);
    chk("midrst_req_wen", 32'(mem_req_wen), 32'd0);
    rstn = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF; mem_rsp_err = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_Mvalid", 32'(Mvalid), 32'd0);

    // Randomized instruction mix.
    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 99);
      r  = (op < 40) || (op >= 90);
      w  = (op >= 40 && op < 75) || (op >= 90);
      if ($urandom_range(0, 9) < 8) begin
        if (r) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 2));
        end
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
      run_txn(r, w, f3, a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle memory-stage unit. Sits between the execute stage and the writeback stage.
- Accepts one instruction per handshake from execute (Evalid/Mready). Performs at most one load or store over a simple request/response data-memory bus.
- Aligns and extends load data, then presents the result to writeback with Mvalid, held until writeback asserts Wready.
- It is the producer side of the Mvalid/Wready handshake.

Parameters:
- DATA_WIDTH, 32, data and address width (fixed at 32 in this version).
- STRB_WIDTH, 4, byte-strobe width (DATA_WIDTH/8).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- Evalid  in  1  execute stage has a valid instruction.
- Mready  out  1  unit can accept an instruction. High only in IDLE.
- MemRead  in  1  instruction is a load.
- MemWrite  in  1  instruction is a store.
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  in  32  effective address / non-memory result.
- WriteData  in  32  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_req_wen  out  1  1 = write.
- mem_req_wdata  out  32  lane-shifted store data.
- mem_req_wstrb  out  4  byte enables (0 for reads).
- mem_rsp_valid  in  1  bus response valid (one cycle pulse).
- mem_rsp_rdata  in  32  raw word read data.
- mem_rsp_err  in  1  bus error with response.
- Mvalid  out  1  result valid to writeback.
- Wready  in  1  writeback ready.
- ReadData  out  32  extended load data (0 for non-loads/errors).
- ALUResultOut  out  32  latched ALUResult.
- MemErr  out  1  access fault (misaligned, illegal funct3, bus error, read+write).

Behaviour:
- Reset (rstn=0 at posedge), all instruction state is abandoned:
  - state=IDLE.
  - Mvalid=0, mem_req_valid=0, MemErr=0.
  - ReadData=0, ALUResultOut=0.
  - mem_req_addr/wdata/wstrb/wen=0.
  - Reset wins over all other events.
- Mready is combinational: Mready = (state==IDLE).
- IDLE:
  - On Evalid at a posedge, latch MemRead, MemWrite, Funct3, ALUResult and WriteData.
  - Classify:
    - a) Neither MemRead nor MemWrite -> DONE, MemErr=0, ReadData=0. Latency: Mvalid high 1 cycle after acceptance.
    - b) Fault -> DONE, MemErr=1, ReadData=0, no bus request. Fault is any of: MemRead&&MemWrite; H/HU with addr[0]=1; W with addr[1:0]!=0; load Funct3 in {011,110,111}; store Funct3 not in {000,001,010}.
    - c) Otherwise -> REQ, with mem_req_* driven from registers in the same cycle the state becomes REQ.
- REQ:
  - mem_req_valid=1; all request fields held stable.
  - On mem_req_ready=1 at posedge -> WAIT_RSP, mem_req_valid=0.
- WAIT_RSP:
  - On mem_rsp_valid=1 -> DONE; MemErr=mem_rsp_err.
  - Load without error: ReadData = selected lane.
    - B/BU: byte addr[1:0]. H/HU: halfword addr[1].
    - Sign-extended for B/H, zero-extended for BU/HU, W passes through.
  - Stores and errors: ReadData=0.
  - A response arriving in the same cycle as the request handshake is not legal; it is ignored.
- DONE:
  - Mvalid=1; ReadData, ALUResultOut and MemErr held stable.
  - Transfer occurs when Mvalid&&Wready at posedge -> IDLE, Mvalid=0.
  - No new acceptance in that cycle (one-cycle bubble).
  - If Wready is already high on entry to DONE, Mvalid is high for exactly one cycle.
- Store lane shaping:
  - SB: wdata={4{WriteData[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteData[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=WriteData, wstrb=4'b1111.
- Reads: mem_req_wen=0, wstrb=0.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Exactly one bus request is issued per memory instruction. No request is ever issued for faults or non-memory instructions.

Test Plan:
- Non-memory op: Evalid=1, MemRead=MemWrite=0, ALUResult=0x12345678, Wready=1 -> Mvalid high next cycle for 1 cycle; ALUResultOut=0x12345678, ReadData=0, no mem_req_valid.
- LB sign-extend with 2-cycle bus stall: addr=0x1003, rdata=0x80FF_0000 -> mem_req_addr=0x1000, wen=0; ReadData=0xFFFFFF80; MemErr=0; Mvalid 1 cycle after rsp. Repeat as LBU -> 0x00000080.
- SH to addr=0x2002, WriteData=0xDEADBEEF -> wdata=0xBEEFBEEF, wstrb=4'b1100, wen=1; after rsp, Mvalid=1, ReadData=0.
- Misaligned LW at addr=0x3001 -> no mem_req_valid ever; Mvalid next cycle with MemErr=1. Also cover bus error: LW at 0x3000, mem_rsp_err=1 -> MemErr=1, ReadData=0.
- Backpressure: hold Wready=0 for 5 cycles in DONE -> Mvalid, ReadData and MemErr stable, Mready=0 throughout; Wready=1 -> IDLE next cycle, Mready=1.
- Reset mid-operation: assert rstn=0 during WAIT_RSP, then pulse mem_rsp_valid after reset -> all outputs reset, state IDLE, stray response ignored (Mvalid stays 0).
